dmem_unit: RTL
==============

Name: dmem_unit

Overview:
Data-memory stage downstream of the ALU in the MIPS datapath. It takes the ALU-computed address, memread/memwrite and rt write data, and performs word LW/SW against an internal word array with a configurable access latency. While an access is in progress it raises stall, which holds the PC. It returns read data to the memtoreg mux and flags illegal accesses.

Parameters:
DEPTH, 256, number of 32-bit words in the array (power of two)
BASE, 32'h10010000, byte address of word 0
LATENCY, 2, wait cycles spent in BUSY before the access commits (1..15)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high; forces the FSM to IDLE and clears registered outputs
memread  input  1  LW request from control
memwrite  input  1  SW request from control
address  input  32  byte address from the ALU
write_data  input  32  store data (rt)
read_data  output  32  registered load result
stall  output  1  high while an access is pending; PC must not advance
fault  output  1  combinational; illegal request, no access performed

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: state=IDLE, count=0, read_data=32'h0. stall and fault are combinational and therefore 0 after reset unless a request is present. Array contents are not cleared by reset; they initialise to 0 at time zero.
- Word index = (address - BASE) >> 2. The request is legal only when all of the following hold: address[1:0]==0; BASE <= address < BASE + 4*DEPTH; exactly one of memread/memwrite is high.
- fault = (memread|memwrite) & ~legal, evaluated only in IDLE; it is 0 in BUSY and DONE. A faulting request does not stall, does not access memory and leaves read_data unchanged.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = legal request.
  - On a legal request, latch op, index and write_data, set count=LATENCY-1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - stall=1.
  - While count != 0, decrement count.
  - When count==0, commit at that posedge and go to DONE. For a write: mem[index] <= latched data. For a read: read_data <= mem[index].
- DONE:
  - stall=0 for exactly one cycle, so the PC advances at the end of this cycle; read_data is valid.
  - Go to IDLE unconditionally. Inputs sampled in DONE are ignored, so the same instruction is never re-accepted.
- Timing: total stall cycles per legal access = 1 + LATENCY. Cycle n+1+LATENCY is DONE.
- Requests use the values latched in IDLE; input changes during BUSY are ignored.
- read_data holds its value until the next completed read; writes do not change it.
- Reset mid-BUSY: the latched access is abandoned, no write is committed, read_data returns to 0 and the FSM returns to IDLE.

Decomposition:
- Shared header (alongside mips.h):
  - state encodings DMEM_IDLE=2'd0, DMEM_BUSY=2'd1, DMEM_DONE=2'd2
  - default BASE constant DATA_BASE=32'h10010000
- One natural sub-module, dmem_array: a synchronous-write, registered-read DEPTH×32 array with we, re, index, wdata and rdata. dmem_unit holds the FSM, latency counter and legality checks.

Test Plan:
- Reset, then SW: address=0x10010004, write_data=0xDEADBEEF, LATENCY=2 -> stall high for 3 cycles, low in the 4th; mem[1]=0xDEADBEEF; read_data stays 0; fault=0.
- LW from 0x10010004 after the test above -> stall 3 cycles; read_data=0xDEADBEEF in the DONE cycle, held afterwards with memread=0.
- Misaligned LW at 0x10010006, and out-of-range LW at 0x10010400 (DEPTH=256) -> fault=1 in the same cycle, stall=0, read_data unchanged, no state change.
- memread=memwrite=1 at a legal address -> fault=1, no stall, memory unchanged.
- SW to 0x10010008 of 0x12345678, with reset pulsed (asynchronously, off-edge) during BUSY -> stall drops immediately; a following LW of 0x10010008 returns 0x00000000.
- Back-to-back LW/LW, requests held through DONE and then changed -> each access stalls exactly 1+LATENCY cycles; DONE never re-issues; LATENCY=1 variant gives 2-cycle stalls.

Source files
------------

// File: rtl/dmem_unit_pkg.sv
// Shared definitions for the data-memory stage.
// State encodings and the default data segment base.
package dmem_unit_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DATA_BASE = 32'h1001_0000;

endpackage

// File: rtl/dmem_array.sv
// Word array for the data-memory stage.
// Synchronous write, registered read port.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] index,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // Contents survive reset; only the read register is cleared.
    logic [31:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage: word LW/SW with fixed access latency.
// Stalls the PC while an access is in flight; flags illegal requests.
module dmem_unit
    import dmem_unit_pkg::*;
#(
    parameter int          DEPTH   = 256,
    parameter logic [31:0] BASE    = DATA_BASE,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault
);

    localparam int          IW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t   state;
    dmem_state_t   state_n;
    logic [3:0]    count;
    logic          op_wr;
    logic [IW-1:0] idx_q;
    logic [31:0]   wdata_q;

    logic [31:0] offset;
    logic        legal;
    logic        req;
    logic        accept;
    logic        commit;

    // Addresses below BASE wrap to large offsets and fail the range test.
    assign offset = address - BASE;
    assign req    = memread | memwrite;
    assign legal  = (address[1:0] == 2'b00)
                  & (offset < SPAN)
                  & (memread ^ memwrite);

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        fault   = 1'b0;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state)
            DMEM_IDLE: begin
                stall = legal;
                fault = req & ~legal;
                if (legal) begin
                    accept  = 1'b1;
                    state_n = DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                stall = 1'b1;
                if (count == 4'd0) begin
                    commit  = 1'b1;
                    state_n = DMEM_DONE;
                end
            end
            DMEM_DONE: begin
                state_n = DMEM_IDLE;
            end
            default: begin
                state_n = DMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= DMEM_IDLE;
            count   <= 4'd0;
            op_wr   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                count   <= CNT_INIT;
                op_wr   <= memwrite;
                idx_q   <= offset[IW+1:2];
                wdata_q <= write_data;
            end else if (state == DMEM_BUSY && count != 4'd0) begin
                count <= count - 4'd1;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (commit & op_wr),
        .re    (commit & ~op_wr),
        .index (idx_q),
        .wdata (wdata_q),
        .rdata (read_data)
    );

endmodule
